// File: rtl/axi_burst_master.sv
// AXI4 burst master: moves one cache line per request between the cache and memory.
// A read or a write is a single INCR burst of BEATS beats. Errors are reported
// alongside the done pulse rather than stalling the engine.
module axi_burst_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned LINE_WIDTH     = 512
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
    input  logic [LINE_WIDTH-1:0]       i_data,
    input  logic                        i_start_read,
    input  logic                        i_start_write,
    output logic                        o_ready,
    output logic [LINE_WIDTH-1:0]       o_data,
    output logic                        o_read_done,
    output logic                        o_write_done,
    output logic                        o_error,

    output logic                        AR_VALID,
    input  logic                        AR_READY,
    output logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
    output logic [7:0]                  AR_LEN,
    output logic [2:0]                  AR_SIZE,
    output logic [1:0]                  AR_BURST,
    output logic [2:0]                  AR_PROT,

    input  logic [AXI_DATA_WIDTH-1:0]   R_DATA,
    input  logic [1:0]                  R_RESP,
    input  logic                        R_LAST,
    input  logic                        R_VALID,
    output logic                        R_READY,

    output logic                        AW_VALID,
    input  logic                        AW_READY,
    output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
    output logic [7:0]                  AW_LEN,
    output logic [2:0]                  AW_SIZE,
    output logic [1:0]                  AW_BURST,
    output logic [2:0]                  AW_PROT,

    output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
    output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
    output logic                        W_LAST,
    output logic                        W_VALID,
    input  logic                        W_READY,

    input  logic [1:0]                  B_RESP,
    input  logic                        B_VALID,
    output logic                        B_READY
);

    localparam int unsigned BEATS  = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(BEATS) + 1;
    localparam int unsigned SIZE_V = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [LINE_WIDTH-1:0] SLOT_MASK = LINE_WIDTH'({AXI_DATA_WIDTH{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WADDR = 3'd3,
        S_WDATA = 3'd4,
        S_WRESP = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]       line_q, line_d;
    logic [LINE_WIDTH-1:0]       data_q, data_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic                        ready_q, ready_d;
    logic                        ar_valid_q, ar_valid_d;
    logic                        r_ready_q, r_ready_d;
    logic                        aw_valid_q, aw_valid_d;
    logic                        w_valid_q, w_valid_d;
    logic [AXI_DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic                        w_last_q, w_last_d;
    logic                        b_ready_q, b_ready_d;
    logic                        rdone_q, rdone_d;
    logic                        wdone_q, wdone_d;
    logic                        oerr_q, oerr_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic cnt_last;
    logic beat_err;
    int unsigned rd_off;

    // Handshakes only ever qualify state updates; VALIDs come from flops.
    assign ar_hs    = ar_valid_q & AR_READY;
    assign r_hs     = r_ready_q  & R_VALID;
    assign aw_hs    = aw_valid_q & AW_READY;
    assign w_hs     = w_valid_q  & W_READY;
    assign b_hs     = b_ready_q  & B_VALID;
    assign cnt_last = (cnt_q == CNT_W'(BEATS - 1));

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            line_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_last_q   <= 1'b0;
            b_ready_q  <= 1'b0;
            rdone_q    <= 1'b0;
            wdone_q    <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_last_q   <= w_last_d;
            b_ready_q  <= b_ready_d;
            rdone_q    <= rdone_d;
            wdone_q    <= wdone_d;
            oerr_q     <= oerr_d;
        end
    end

    // Next-state logic; read wins over a simultaneous write request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start_read)       state_d = S_RADDR;
                else if (i_start_write) state_d = S_WADDR;
            end
            S_RADDR: if (ar_hs)                state_d = S_RDATA;
            S_RDATA: if (r_hs && R_LAST)       state_d = S_IDLE;
            S_WADDR: if (aw_hs)                state_d = S_WDATA;
            S_WDATA: if (w_hs && cnt_last)     state_d = S_WRESP;
            S_WRESP: if (b_hs)                 state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Datapath, error tracking and registered bus controls derived from the next state.
    always_comb begin
        addr_d   = addr_q;
        line_d   = line_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        w_data_d = w_data_q;
        rdone_d  = 1'b0;
        wdone_d  = 1'b0;
        oerr_d   = 1'b0;
        beat_err = 1'b0;
        rd_off   = 32'(cnt_q) * AXI_DATA_WIDTH;

        unique case (state_q)
            S_IDLE: begin
                if (i_start_read || i_start_write) begin
                    addr_d = i_addr;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    if (!i_start_read) line_d = i_data;
                end
            end
            S_RDATA: begin
                if (r_hs) begin
                    // Beats past the end are accepted only to drain the burst.
                    if (32'(cnt_q) < BEATS) begin
                        data_d = (data_q & ~(SLOT_MASK << rd_off))
                               | (LINE_WIDTH'(R_DATA) << rd_off);
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                    beat_err = (R_RESP != 2'b00) | (R_LAST != cnt_last);
                    err_d    = err_q | beat_err;
                    if (R_LAST) begin
                        rdone_d = 1'b1;
                        oerr_d  = err_q | beat_err;
                    end
                end
            end
            S_WDATA: begin
                if (w_hs) cnt_d = cnt_q + CNT_W'(1);
            end
            S_WRESP: begin
                if (b_hs) begin
                    wdone_d = 1'b1;
                    oerr_d  = err_q | (B_RESP != 2'b00);
                end
            end
            default: ;
        endcase

        ready_d    = (state_d == S_IDLE);
        ar_valid_d = (state_d == S_RADDR);
        r_ready_d  = (state_d == S_RDATA);
        aw_valid_d = (state_d == S_WADDR);
        w_valid_d  = (state_d == S_WDATA);
        b_ready_d  = (state_d == S_WRESP);
        w_last_d   = (state_d == S_WDATA) && (cnt_d == CNT_W'(BEATS - 1));
        if (state_d == S_WDATA)
            w_data_d = AXI_DATA_WIDTH'(line_d >> (32'(cnt_d) * AXI_DATA_WIDTH));
    end

    assign o_ready      = ready_q;
    assign o_data       = data_q;
    assign o_read_done  = rdone_q;
    assign o_write_done = wdone_q;
    assign o_error      = oerr_q;

    assign AR_VALID = ar_valid_q;
    assign AR_ADDR  = addr_q;
    assign AR_LEN   = 8'(BEATS - 1);
    assign AR_SIZE  = 3'(SIZE_V);
    assign AR_BURST = 2'b01;
    assign AR_PROT  = 3'b000;
    assign R_READY  = r_ready_q;

    assign AW_VALID = aw_valid_q;
    assign AW_ADDR  = addr_q;
    assign AW_LEN   = 8'(BEATS - 1);
    assign AW_SIZE  = 3'(SIZE_V);
    assign AW_BURST = 2'b01;
    assign AW_PROT  = 3'b000;

    assign W_DATA   = w_data_q;
    assign W_STRB   = {STRB_W{1'b1}};
    assign W_LAST   = w_last_q;
    assign W_VALID  = w_valid_q;
    assign B_READY  = b_ready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: default 32/512 instance plus a 64/256 instance.
module tb_axi_burst_master;

    logic clk;
    logic rst;

    // Default-parameter instance (32-bit bus, 512-bit line, 16 beats).
    logic [63:0]  i_addr;
    logic [511:0] i_data;
    logic         i_start_read, i_start_write;
    logic         o_ready, o_read_done, o_write_done, o_error;
    logic [511:0] o_data;
    logic         AR_VALID, AR_READY;
    logic [63:0]  AR_ADDR;
    logic [7:0]   AR_LEN;
    logic [2:0]   AR_SIZE, AR_PROT;
    logic [1:0]   AR_BURST;
    logic [31:0]  R_DATA;
    logic [1:0]   R_RESP;
    logic         R_LAST, R_VALID, R_READY;
    logic         AW_VALID, AW_READY;
    logic [63:0]  AW_ADDR;
    logic [7:0]   AW_LEN;
    logic [2:0]   AW_SIZE, AW_PROT;
    logic [1:0]   AW_BURST;
    logic [31:0]  W_DATA;
    logic [3:0]   W_STRB;
    logic         W_LAST, W_VALID, W_READY;
    logic [1:0]   B_RESP;
    logic         B_VALID, B_READY;

    // Wide-bus instance (64-bit bus, 256-bit line, 4 beats).
    logic [63:0]  i_addr_b;
    logic [255:0] i_data_b;
    logic         i_start_read_b, i_start_write_b;
    logic         o_ready_b, o_read_done_b, o_write_done_b, o_error_b;
    logic [255:0] o_data_b;
    logic         AR_VALID_b, AR_READY_b;
    logic [63:0]  AR_ADDR_b;
    logic [7:0]   AR_LEN_b;
    logic [2:0]   AR_SIZE_b, AR_PROT_b;
    logic [1:0]   AR_BURST_b;
    logic [63:0]  R_DATA_b;
    logic [1:0]   R_RESP_b;
    logic         R_LAST_b, R_VALID_b, R_READY_b;
    logic         AW_VALID_b, AW_READY_b;
    logic [63:0]  AW_ADDR_b;
    logic [7:0]   AW_LEN_b;
    logic [2:0]   AW_SIZE_b, AW_PROT_b;
    logic [1:0]   AW_BURST_b;
    logic [63:0]  W_DATA_b;
    logic [7:0]   W_STRB_b;
    logic         W_LAST_b, W_VALID_b, W_READY_b;
    logic [1:0]   B_RESP_b;
    logic         B_VALID_b, B_READY_b;

    int n_pass;
    int n_fail;
    int n_total;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_data(i_data), .i_start_read(i_start_read), .i_start_write(i_start_write),
        .o_ready(o_ready), .o_data(o_data), .o_read_done(o_read_done), .o_write_done(o_write_done),
        .o_error(o_error),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_LEN(AR_LEN),
        .AR_SIZE(AR_SIZE), .AR_BURST(AR_BURST), .AR_PROT(AR_PROT),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_LAST(R_LAST), .R_VALID(R_VALID), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_LEN(AW_LEN),
        .AW_SIZE(AW_SIZE), .AW_BURST(AW_BURST), .AW_PROT(AW_PROT),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_LAST(W_LAST), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
    );

    axi_burst_master #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .LINE_WIDTH(256)
    ) dut_b (
        .clk(clk), .rst(rst),
        .i_addr(i_addr_b), .i_data(i_data_b), .i_start_read(i_start_read_b),
        .i_start_write(i_start_write_b),
        .o_ready(o_ready_b), .o_data(o_data_b), .o_read_done(o_read_done_b),
        .o_write_done(o_write_done_b), .o_error(o_error_b),
        .AR_VALID(AR_VALID_b), .AR_READY(AR_READY_b), .AR_ADDR(AR_ADDR_b), .AR_LEN(AR_LEN_b),
        .AR_SIZE(AR_SIZE_b), .AR_BURST(AR_BURST_b), .AR_PROT(AR_PROT_b),
        .R_DATA(R_DATA_b), .R_RESP(R_RESP_b), .R_LAST(R_LAST_b), .R_VALID(R_VALID_b),
        .R_READY(R_READY_b),
        .AW_VALID(AW_VALID_b), .AW_READY(AW_READY_b), .AW_ADDR(AW_ADDR_b), .AW_LEN(AW_LEN_b),
        .AW_SIZE(AW_SIZE_b), .AW_BURST(AW_BURST_b), .AW_PROT(AW_PROT_b),
        .W_DATA(W_DATA_b), .W_STRB(W_STRB_b), .W_LAST(W_LAST_b), .W_VALID(W_VALID_b),
        .W_READY(W_READY_b),
        .B_RESP(B_RESP_b), .B_VALID(B_VALID_b), .B_READY(B_READY_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One read burst on the default instance with a zero-wait slave.
    task automatic do_read(input logic [63:0] addr, input int n, input int last_k,
                           input int err_k, input logic [31:0] base);
        i_addr       = addr;
        i_start_read = 1'b1;
        tick;
        i_start_read = 1'b0;
        chk("ar_valid", 64'(AR_VALID), 64'(1));
        chk("ar_addr", AR_ADDR, addr);
        chk("aw_idle_acc", 64'(AW_VALID), 64'(0));
        AR_READY = 1'b1;
        tick;
        AR_READY = 1'b0;
        chk("ar_valid_drop", 64'(AR_VALID), 64'(0));
        chk("r_ready", 64'(R_READY), 64'(1));
        for (int k = 0; k < n; k++) begin
            R_VALID = 1'b1;
            R_DATA  = base + 32'(k);
            R_LAST  = (k == last_k);
            R_RESP  = (k == err_k) ? 2'b10 : 2'b00;
            tick;
            chk("aw_idle", 64'(AW_VALID), 64'(0));
            if (k != n - 1) chk("rd_done_early", 64'(o_read_done), 64'(0));
        end
        R_VALID = 1'b0;
        R_LAST  = 1'b0;
        R_RESP  = 2'b00;
    endtask

    // One write burst on the default instance; optionally W_READY toggles each cycle.
    task automatic do_write(input logic [63:0] addr, input logic [31:0] base,
                            input logic toggle, input logic [1:0] bresp);
        int k;
        int c;
        for (int j = 0; j < 16; j++) i_data[j*32 +: 32] = base + 32'(j);
        i_addr        = addr;
        i_start_write = 1'b1;
        tick;
        i_start_write = 1'b0;
        chk("aw_valid", 64'(AW_VALID), 64'(1));
        chk("aw_addr", AW_ADDR, addr);
        chk("w_before_aw", 64'(W_VALID), 64'(0));
        AW_READY = 1'b1;
        tick;
        AW_READY = 1'b0;
        chk("aw_valid_drop", 64'(AW_VALID), 64'(0));
        k = 0;
        c = 0;
        while (k < 16 && c < 100) begin
            chk("w_valid", 64'(W_VALID), 64'(1));
            chk("w_data", 64'(W_DATA), 64'(base + 32'(k)));
            chk("w_last", 64'(W_LAST), 64'(k == 15));
            W_READY = toggle ? (c % 2 == 0) : 1'b1;
            tick;
            if (W_READY) k++;
            c++;
        end
        W_READY = 1'b0;
        chk("w_beats", 64'(k), 64'(16));
        chk("w_valid_end", 64'(W_VALID), 64'(0));
        chk("b_ready", 64'(B_READY), 64'(1));
        B_VALID = 1'b1;
        B_RESP  = bresp;
        tick;
        B_VALID = 1'b0;
        B_RESP  = 2'b00;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        rst = 1'b1;
        i_addr = '0; i_data = '0; i_start_read = 1'b0; i_start_write = 1'b0;
        AR_READY = 1'b0; R_DATA = '0; R_RESP = 2'b00; R_LAST = 1'b0; R_VALID = 1'b0;
        AW_READY = 1'b0; W_READY = 1'b0; B_RESP = 2'b00; B_VALID = 1'b0;
        i_addr_b = '0; i_data_b = '0; i_start_read_b = 1'b0; i_start_write_b = 1'b0;
        AR_READY_b = 1'b0; R_DATA_b = '0; R_RESP_b = 2'b00; R_LAST_b = 1'b0; R_VALID_b = 1'b0;
        AW_READY_b = 1'b0; W_READY_b = 1'b0; B_RESP_b = 2'b00; B_VALID_b = 1'b0;
        tick;
        tick;

        // Reset state
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_ar_valid", 64'(AR_VALID), 64'(0));
        chk("rst_r_ready", 64'(R_READY), 64'(0));
        chk("rst_aw_valid", 64'(AW_VALID), 64'(0));
        chk("rst_w_valid", 64'(W_VALID), 64'(0));
        chk("rst_w_last", 64'(W_LAST), 64'(0));
        chk("rst_b_ready", 64'(B_READY), 64'(0));
        chk("rst_rd_done", 64'(o_read_done), 64'(0));
        chk("rst_data", o_data[63:0], 64'(0));
        rst = 1'b0;
        tick;

        // Constant burst attributes for the default geometry
        chk("ar_len", 64'(AR_LEN), 64'(15));
        chk("ar_size", 64'(AR_SIZE), 64'(2));
        chk("ar_burst", 64'(AR_BURST), 64'(1));
        chk("aw_len", 64'(AW_LEN), 64'(15));
        chk("w_strb", 64'(W_STRB), 64'(4'hF));

        // Plain read, beats 0..15
        do_read(64'h1000, 16, 15, -1, 32'h0);
        chk("rd1_done", 64'(o_read_done), 64'(1));
        chk("rd1_err", 64'(o_error), 64'(0));
        chk("rd1_ready", 64'(o_ready), 64'(1));
        chk("rd1_beat0", 64'(o_data[31:0]), 64'(0));
        chk("rd1_beat7", 64'(o_data[255:224]), 64'(7));
        chk("rd1_beat15", 64'(o_data[511:480]), 64'(32'hF));
        tick;
        chk("rd1_done_pulse", 64'(o_read_done), 64'(0));

        // Write with W_READY toggling, OKAY response
        do_write(64'h1000, 32'h10, 1'b1, 2'b00);
        chk("wr1_done", 64'(o_write_done), 64'(1));
        chk("wr1_err", 64'(o_error), 64'(0));
        chk("rd_line_held", 64'(o_data[511:480]), 64'(32'hF));
        tick;
        chk("wr1_done_pulse", 64'(o_write_done), 64'(0));

        // Simultaneous read and write requests; write held until accepted
        i_start_write = 1'b1;
        do_read(64'h2000, 16, 15, -1, 32'h100);
        chk("sim_rd_done", 64'(o_read_done), 64'(1));
        chk("sim_rd_err", 64'(o_error), 64'(0));
        chk("sim_rd_beat1", 64'(o_data[63:32]), 64'(32'h101));
        do_write(64'h2000, 32'h20, 1'b0, 2'b00);
        chk("sim_wr_done", 64'(o_write_done), 64'(1));
        chk("sim_wr_err", 64'(o_error), 64'(0));
        tick;

        // Missing LAST on beat 15: drain extra beats, report error
        do_read(64'h3000, 18, 17, -1, 32'h300);
        chk("drain_done", 64'(o_read_done), 64'(1));
        chk("drain_err", 64'(o_error), 64'(1));
        chk("drain_beat15", 64'(o_data[511:480]), 64'(32'h30F));
        tick;

        // SLVERR on beat 3
        do_read(64'h3000, 16, 15, 3, 32'h400);
        chk("slverr_done", 64'(o_read_done), 64'(1));
        chk("slverr_err", 64'(o_error), 64'(1));
        chk("slverr_beat3", 64'(o_data[127:96]), 64'(32'h403));
        tick;
        chk("slverr_pulse", 64'(o_read_done), 64'(0));

        // Early LAST on beat 10; slots 11..15 keep the previous line
        do_read(64'h4000, 11, 10, -1, 32'h500);
        chk("early_done", 64'(o_read_done), 64'(1));
        chk("early_err", 64'(o_error), 64'(1));
        chk("early_beat10", 64'(o_data[351:320]), 64'(32'h50A));
        chk("early_beat11", 64'(o_data[383:352]), 64'(32'h40B));
        tick;

        // Clean read after errors: sticky flag must be cleared on accept
        do_read(64'h4100, 16, 15, -1, 32'h700);
        chk("clean_done", 64'(o_read_done), 64'(1));
        chk("clean_err", 64'(o_error), 64'(0));
        tick;

        // 64-bit bus, 256-bit line: 4 beats, SLVERR write response
        chk("b_ar_len", 64'(AR_LEN_b), 64'(3));
        chk("b_ar_size", 64'(AR_SIZE_b), 64'(3));
        chk("b_aw_size", 64'(AW_SIZE_b), 64'(3));
        chk("b_w_strb", 64'(W_STRB_b), 64'(8'hFF));
        for (int j = 0; j < 4; j++) i_data_b[j*64 +: 64] = 64'h100 + 64'(j);
        i_addr_b        = 64'h8000;
        i_start_write_b = 1'b1;
        tick;
        i_start_write_b = 1'b0;
        chk("b_aw_valid", 64'(AW_VALID_b), 64'(1));
        chk("b_aw_addr", AW_ADDR_b, 64'h8000);
        AW_READY_b = 1'b1;
        tick;
        AW_READY_b = 1'b0;
        W_READY_b  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("b_w_valid", 64'(W_VALID_b), 64'(1));
            chk("b_w_data", W_DATA_b, 64'h100 + 64'(k));
            chk("b_w_last", 64'(W_LAST_b), 64'(k == 3));
            tick;
        end
        W_READY_b = 1'b0;
        chk("b_b_ready", 64'(B_READY_b), 64'(1));
        B_VALID_b = 1'b1;
        B_RESP_b  = 2'b10;
        tick;
        B_VALID_b = 1'b0;
        B_RESP_b  = 2'b00;
        chk("b_wr_done", 64'(o_write_done_b), 64'(1));
        chk("b_wr_err", 64'(o_error_b), 64'(1));
        tick;

        // Reset during beat 5 of a write abandons it with no done pulse
        for (int j = 0; j < 16; j++) i_data[j*32 +: 32] = 32'h40 + 32'(j);
        i_addr        = 64'h9000;
        i_start_write = 1'b1;
        tick;
        i_start_write = 1'b0;
        AW_READY = 1'b1;
        tick;
        AW_READY = 1'b0;
        W_READY  = 1'b1;
        for (int k = 0; k < 5; k++) tick;
        chk("rstw_beat5", 64'(W_DATA), 64'(32'h45));
        chk("rstw_valid_pre", 64'(W_VALID), 64'(1));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        W_READY = 1'b0;
        chk("rstw_w_valid", 64'(W_VALID), 64'(0));
        chk("rstw_w_last", 64'(W_LAST), 64'(0));
        chk("rstw_ready", 64'(o_ready), 64'(1));
        chk("rstw_done", 64'(o_write_done), 64'(0));
        tick;
        chk("rstw_done2", 64'(o_write_done), 64'(0));
        chk("rstw_aw_idle", 64'(AW_VALID), 64'(0));

        // Engine usable again after the abort
        do_read(64'h5000, 16, 15, -1, 32'h600);
        chk("post_rst_done", 64'(o_read_done), 64'(1));
        chk("post_rst_err", 64'(o_error), 64'(0));
        chk("post_rst_beat15", 64'(o_data[511:480]), 64'(32'h60F));
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
Parametrised AXI4 burst master that moves one cache line (LINE_WIDTH bits) between the cache subsystem and external memory per request. Supports read and write in one block. Correct burst length and size are derived from parameters. Response errors and LAST-framing errors are reported instead of hanging. Sits between the cache FSM and the AXI interconnect.

Parameters:
AXI_ADDR_WIDTH, 64, address width of AR/AW channels and i_addr.
AXI_DATA_WIDTH, 32, AXI data bus width; power of two, 8..256.
LINE_WIDTH, 512, line size; integer multiple of AXI_DATA_WIDTH; BEATS = LINE_WIDTH/AXI_DATA_WIDTH, 1..256.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
i_addr  in  AXI_ADDR_WIDTH  line base address, sampled at request accept.
i_data  in  LINE_WIDTH  write line, sampled at write accept.
i_start_read  in  1  read request.
i_start_write  in  1  write request.
o_ready  out  1  high in IDLE; a request is accepted when o_ready & start.
o_data  out  LINE_WIDTH  assembled read line; beat k in bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
o_read_done  out  1  one-cycle pulse, read line complete.
o_write_done  out  1  one-cycle pulse, write response received.
o_error  out  1  valid with done pulse: non-OKAY RESP or LAST-framing error seen in that transaction.
AR_VALID/AR_READY/AR_ADDR/AR_LEN[7:0]/AR_SIZE[2:0]/AR_BURST[1:0]/AR_PROT[2:0]  AXI4 read address.
R_DATA/R_RESP[1:0]/R_LAST/R_VALID/R_READY  AXI4 read data.
AW_VALID/AW_READY/AW_ADDR/AW_LEN/AW_SIZE/AW_BURST/AW_PROT  AXI4 write address.
W_DATA/W_STRB/W_LAST/W_VALID/W_READY  AXI4 write data.
B_RESP[1:0]/B_VALID/B_READY  AXI4 write response.

Behaviour:
- Constants: AR_LEN = AW_LEN = BEATS-1; AR_SIZE = AW_SIZE = log2(AXI_DATA_WIDTH/8); BURST = 2'b01 (INCR); PROT = 3'b000; W_STRB all ones.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- Reset: state IDLE; all VALID/READY outputs, W_LAST, o_read_done, o_write_done, o_error = 0; o_data = 0; beat counter = 0. Reset mid-transaction abandons it; no done pulse.
- IDLE: o_ready = 1. i_start_read takes priority over simultaneous i_start_write (write stays pending if held). Accept registers i_addr (and i_data for write), clears error flag, moves to RADDR or WADDR next cycle.
- RADDR: AR_VALID = 1, AR_ADDR stable until AR_READY; on handshake -> RDATA.
- RDATA: R_READY = 1. Each R handshake writes R_DATA into beat slot [count] of o_data, count++. R_RESP != 0 sets error flag. Error flag also set if R_LAST = 1 on a beat other than BEATS-1, or R_LAST = 0 on beat BEATS-1.
- RDATA exit: on handshake with R_LAST = 1 -> IDLE, o_read_done pulses next cycle with o_error. If count reaches BEATS without R_LAST, stay and keep accepting (data discarded) until R_LAST so the bus drains.
- WADDR: AW_VALID = 1 until AW_READY; -> WDATA. Data is not sent before the AW handshake.
- WDATA: W_VALID = 1, W_DATA = line slice [count], W_LAST = (count == BEATS-1). Data, LAST and VALID hold while W_READY = 0. After the LAST handshake -> WRESP.
- WRESP: B_READY = 1. On B handshake -> IDLE, o_write_done pulses with o_error = (B_RESP != 0) | sticky flag. Non-OKAY responses are not retried.
- o_data holds the last read line until the next read's first beat.
- Beat counter width is clog2(BEATS)+1. BEATS = 1: LAST on the first beat.
- No combinational path from any AXI input to any VALID output. Done pulse latency = 1 cycle after the final handshake.

Test Plan:
- Read, defaults, zero-wait slave, addr 0x1000: AR_LEN = 15, AR_SIZE = 2. Beats 0x0..0xF with LAST on 16th -> o_data[31:0] = 0, o_data[511:480] = 0xF, o_read_done 1 cycle, o_error = 0.
- Write, i_data = {16 words 0x10+k}, W_READY toggling 1/0 every cycle: W_DATA sequence 0x10..0x1F held across stalls, W_LAST only on 0x1F, B_RESP = 0 -> o_write_done, o_error = 0.
- Simultaneous i_start_read & i_start_write: AR_VALID first, AW_VALID = 0 until read done. Write then proceeds.
- Read with R_LAST on beat 10 -> o_read_done with o_error = 1. Also R_RESP = SLVERR on beat 3 -> o_error = 1.
- AXI_DATA_WIDTH = 64, LINE_WIDTH = 256: AR_LEN = 3, AR_SIZE = 3, W_STRB = 0xFF. Write B_RESP = 2'b10 -> o_error = 1.
- rst asserted during WDATA beat 5 -> next cycle W_VALID = 0, state IDLE, o_ready = 1, no done pulse.
